mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/cpu_pkg.sv | 19 +
 rtl/starve_ctr.sv | 36 +++
 rtl/mem_arbiter.sv | 111 +++++++++++
 tb/tb_mem_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-side types: response-state encoding and memory owner encoding,
// reused by the arbiter and by future cache and bus blocks.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_RESP = 2'd1,
    D_RESP  = 2'd2
  } resp_state_e;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_IF   = 2'd1,
    OWNER_D    = 2'd2
  } owner_e;

  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/starve_ctr.sv
// Saturating counter of consecutive data grants that a pending fetch has
// been made to wait through; at_max tells the arbiter to let fetch win.
module starve_ctr
  import cpu_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    inc,
  input  logic                    clr,
  input  logic [STARVE_CNT_W-1:0] sat_val,
  output logic                    at_max
);

  logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

  // Clear has priority over increment; the count never moves past sat_val.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q < sat_val)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max = (cnt_q == sat_val);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between the fetch and data ports, with data
// priority bounded by a starvation limit and a one-cycle read response FSM.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter int STARVE = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [AWIDTH-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DWIDTH-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [AWIDTH-1:0] d_addr,
  input  logic [DWIDTH-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DWIDTH-1:0] d_rdata,
  output logic              mem_ramR,
  output logic              mem_ramW,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata
);

  localparam logic [STARVE_CNT_W-1:0] SatVal = STARVE_CNT_W'(STARVE);

  owner_e      owner;
  resp_state_e respState_q, respState_d;
  logic        starveAtMax;
  logic        starveInc;
  logic        starveClr;

  // Grants are held off while reset is low so every output reads zero.
  always_comb begin
    owner = OWNER_NONE;
    if (reset) begin
      if (if_req && (!d_req || starveAtMax)) begin
        owner = OWNER_IF;
      end else if (d_req) begin
        owner = OWNER_D;
      end
    end
  end

  assign if_gnt    = (owner == OWNER_IF);
  assign d_gnt     = (owner == OWNER_D);
  assign starveInc = d_gnt && if_req;
  assign starveClr = if_gnt || !if_req;

  starve_ctr u_starve_ctr (
    .clock   (clock),
    .reset   (reset),
    .inc     (starveInc),
    .clr     (starveClr),
    .sat_val (SatVal),
    .at_max  (starveAtMax)
  );

  always_comb begin
    mem_ramR  = 1'b0;
    mem_ramW  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (owner)
      OWNER_IF: begin
        mem_ramR = 1'b1;
        mem_addr = if_addr;
      end
      OWNER_D: begin
        mem_addr = d_addr;
        if (d_we) begin
          mem_ramW  = 1'b1;
          mem_wdata = d_wdata;
        end else begin
          mem_ramR = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Every state follows the same rule, so back-to-back reads never bubble.
  always_comb begin
    respState_d = IDLE;
    if (owner == OWNER_IF) begin
      respState_d = IF_RESP;
    end else if ((owner == OWNER_D) && !d_we) begin
      respState_d = D_RESP;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      respState_q <= IDLE;
    end else begin
      respState_q <= respState_d;
    end
  end

  assign if_rvalid = (respState_q == IF_RESP);
  assign d_rvalid  = (respState_q == D_RESP);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid  ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed table-driven bench for mem_arbiter plus hand-written reset
// sequences; one table row is one clock cycle of stimulus and expectation.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_ramR;
  logic        mem_ramW;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        ifReq;
    logic [31:0] ifAddr;
    logic        dReq;
    logic        dWe;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    logic [31:0] memRdata;
    logic        ifGnt;
    logic        dGnt;
    logic        ramR;
    logic        ramW;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic        ifRvalid;
    logic [31:0] ifRdata;
    logic        dRvalid;
    logic [31:0] dRdata;
  } vec_t;

  localparam int NumVec = 16;
  vec_t vec [NumVec];

  mem_arbiter #(
    .DWIDTH (32),
    .AWIDTH (32),
    .STARVE (3)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_ramR  (mem_ramR),
    .mem_ramW  (mem_ramW),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    if_req    = v.ifReq;
    if_addr   = v.ifAddr;
    d_req     = v.dReq;
    d_we      = v.dWe;
    d_addr    = v.dAddr;
    d_wdata   = v.dWdata;
    mem_rdata = v.memRdata;
  endtask

  function automatic logic anyOutput();
    return |{if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             mem_ramR, mem_ramW, mem_addr, mem_wdata};
  endfunction

  initial begin
    // Columns: ifReq ifAddr dReq dWe dAddr dWdata memRdata |
    //          ifGnt dGnt ramR ramW memAddr memWdata ifRv ifRdata dRv dRdata
    vec[0]  = '{1, 32'h10, 0, 0, 32'h0, 32'h0, 32'h0,
                1, 0, 1, 0, 32'h10, 32'h0, 0, 32'h0, 0, 32'h0};
    vec[1]  = '{0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h00A00093,
                0, 0, 0, 0, 32'h0, 32'h0, 1, 32'h00A00093, 0, 32'h0};
    vec[2]  = '{1, 32'h20, 1, 0, 32'h200, 32'h13579BDF, 32'h0,
                0, 1, 1, 0, 32'h200, 32'h0, 0, 32'h0, 0, 32'h0};
    vec[3]  = '{0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h11112222,
                0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 1, 32'h11112222};
    vec[4]  = '{1, 32'h30, 1, 0, 32'h300, 32'h0BADF00D, 32'h0,
                0, 1, 1, 0, 32'h300, 32'h0, 0, 32'h0, 0, 32'h0};
    vec[5]  = '{1, 32'h30, 1, 0, 32'h300, 32'h0BADF00D, 32'h55,
                0, 1, 1, 0, 32'h300, 32'h0, 0, 32'h0, 1, 32'h55};
    vec[6]  = '{1, 32'h30, 1, 0, 32'h300, 32'h0BADF00D, 32'h66,
                0, 1, 1, 0, 32'h300, 32'h0, 0, 32'h0, 1, 32'h66};
    vec[7]  = '{1, 32'h30, 1, 0, 32'h300, 32'h0BADF00D, 32'h77,
                1, 0, 1, 0, 32'h30, 32'h0, 0, 32'h0, 1, 32'h77};
    vec[8]  = '{1, 32'h30, 1, 0, 32'h300, 32'h0BADF00D, 32'h88,
                0, 1, 1, 0, 32'h300, 32'h0, 1, 32'h88, 0, 32'h0};
    vec[9]  = '{0, 32'h0, 1, 1, 32'h40, 32'hDEADBEEF, 32'h99,
                0, 1, 0, 1, 32'h40, 32'hDEADBEEF, 0, 32'h0, 1, 32'h99};
    vec[10] = '{0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h12345678,
                0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0};
    vec[11] = '{1, 32'h50, 0, 0, 32'h0, 32'h0, 32'h0,
                1, 0, 1, 0, 32'h50, 32'h0, 0, 32'h0, 0, 32'h0};
    vec[12] = '{0, 32'h0, 1, 0, 32'h60, 32'h0, 32'hAAAA0001,
                0, 1, 1, 0, 32'h60, 32'h0, 1, 32'hAAAA0001, 0, 32'h0};
    vec[13] = '{1, 32'h70, 0, 0, 32'h0, 32'h0, 32'hAAAA0002,
                1, 0, 1, 0, 32'h70, 32'h0, 0, 32'h0, 1, 32'hAAAA0002};
    vec[14] = '{0, 32'h0, 0, 0, 32'h0, 32'h0, 32'hAAAA0003,
                0, 0, 0, 0, 32'h0, 32'h0, 1, 32'hAAAA0003, 0, 32'h0};
    vec[15] = '{0, 32'h0, 0, 0, 32'h0, 32'h0, 32'hCAFE0000,
                0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0};

    // Requests are raised during reset to show the grants stay gated off.
    reset     = 1'b0;
    if_req    = 1'b1;
    if_addr   = 32'h1234;
    d_req     = 1'b1;
    d_we      = 1'b1;
    d_addr    = 32'h5678;
    d_wdata   = 32'hFFFF_FFFF;
    mem_rdata = 32'hFFFF_FFFF;
    #3;
    checkOutput("resetOutputsZero", 64'(anyOutput()), 64'h0);
    repeat (2) @(posedge clock);
    #1;
    checkOutput("resetOutputsZeroAfterEdges", 64'(anyOutput()), 64'h0);
    if_req    = 1'b0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    if_addr   = '0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_rdata = '0;
    #2;
    reset = 1'b1;

    for (int i = 0; i < NumVec; i++) begin
      @(posedge clock);
      #1;
      applyStimulus(vec[i]);
      #3;
      checkOutput($sformatf("r%0d.ifGnt", i),    64'(if_gnt),    64'(vec[i].ifGnt));
      checkOutput($sformatf("r%0d.dGnt", i),     64'(d_gnt),     64'(vec[i].dGnt));
      checkOutput($sformatf("r%0d.ramR", i),     64'(mem_ramR),  64'(vec[i].ramR));
      checkOutput($sformatf("r%0d.ramW", i),     64'(mem_ramW),  64'(vec[i].ramW));
      checkOutput($sformatf("r%0d.memAddr", i),  64'(mem_addr),  64'(vec[i].memAddr));
      checkOutput($sformatf("r%0d.memWdata", i), 64'(mem_wdata), 64'(vec[i].memWdata));
      checkOutput($sformatf("r%0d.ifRvalid", i), 64'(if_rvalid), 64'(vec[i].ifRvalid));
      checkOutput($sformatf("r%0d.ifRdata", i),  64'(if_rdata),  64'(vec[i].ifRdata));
      checkOutput($sformatf("r%0d.dRvalid", i),  64'(d_rvalid),  64'(vec[i].dRvalid));
      checkOutput($sformatf("r%0d.dRdata", i),   64'(d_rdata),   64'(vec[i].dRdata));
    end

    // Fetch granted, then reset asserted mid-cycle before the response edge.
    @(posedge clock);
    #1;
    if_req    = 1'b1;
    if_addr   = 32'h80;
    d_req     = 1'b0;
    d_we      = 1'b0;
    mem_rdata = 32'h0;
    #3;
    checkOutput("midRead.ifGnt",   64'(if_gnt),   64'h1);
    checkOutput("midRead.memAddr", 64'(mem_addr), 64'h80);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midRead.outputsZeroInReset", 64'(anyOutput()), 64'h0);
    if_req = 1'b0;
    @(posedge clock);
    #1;
    mem_rdata = 32'hFEEDFACE;
    checkOutput("midRead.noRvalidInReset", 64'(anyOutput()), 64'h0);
    #2;
    reset   = 1'b1;
    if_req  = 1'b1;
    if_addr = 32'h90;
    #1;
    checkOutput("afterReset.ifRvalid", 64'(if_rvalid), 64'h0);
    checkOutput("afterReset.ifRdata",  64'(if_rdata),  64'h0);
    checkOutput("afterReset.ifGnt",    64'(if_gnt),    64'h1);
    checkOutput("afterReset.memAddr",  64'(mem_addr),  64'h90);
    checkOutput("afterReset.ramR",     64'(mem_ramR),  64'h1);
    @(posedge clock);
    #1;
    if_req    = 1'b0;
    if_addr   = '0;
    mem_rdata = 32'h0000BEEF;
    #3;
    checkOutput("afterReset.respValid", 64'(if_rvalid), 64'h1);
    checkOutput("afterReset.respData",  64'(if_rdata),  64'h0000BEEF);
    checkOutput("afterReset.dRvalid",   64'(d_rvalid),  64'h0);
    @(posedge clock);
    #1;
    checkOutput("final.idleOutputs", 64'(anyOutput()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
